// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: region codes, status offsets, lane rules.
// Latency: none (declarations only).
// Backpressure: not applicable.
package data_mem_pkg;

  // Address regions the responder decodes a request into
  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_STAT = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // Byte offsets of the status registers from the window base
  localparam logic [31:0] STAT_CNT_OFF  = 32'h0000_0000;
  localparam logic [31:0] STAT_ADDR_OFF = 32'h0000_0004;
  localparam logic [31:0] STAT_CLR_OFF  = 32'h0000_0008;

  // Only naturally aligned byte, halfword and word lane groups are accepted
  function automatic logic byteen_legal(input logic [3:0] byteen);
    logic ok;
    case (byteen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ram_bytelane.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: read data appears one clock after a read is enabled; writes land on the same edge.
// Backpressure: none; the read register holds its value while no read is enabled.
module ram_bytelane #(
  parameter int WORDS = 1024,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(WORDS),
  localparam int NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [NB-1:0]    i_be,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [WORDS];
  logic [WIDTH-1:0] r_rdata;

  // Write only the enabled byte lanes; the rest of the word is preserved
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Capture the addressed word on a read; hold otherwise
  always_ff @(posedge clk) begin
    if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target: byte-writable RAM plus a fault status window (count, last address, clear).
// Latency: every accepted request answers one clock later via mem_rdata / mem_err.
// Backpressure: none; a request is accepted on every edge with mem_req=1 outside reset.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              RAM_WORDS = 1024,
  parameter logic [XLEN-1:0] RAM_BASE  = 32'h1000_0000,
  parameter logic [XLEN-1:0] STAT_BASE = 32'h1FFF_FF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN/8-1:0] mem_byteen,
  input  logic              mem_we,
  input  logic              mem_req,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_err
);

  localparam int              AW       = $clog2(RAM_WORDS);
  localparam int              NB       = XLEN / 8;
  localparam logic [XLEN-1:0] RAM_SPAN = XLEN'(4 * RAM_WORDS);
  localparam logic [XLEN-1:0] RAM_MASK = ~(RAM_SPAN - XLEN'(1));

  region_e           w_region;
  logic [XLEN-1:0]   w_stat_off;
  logic              w_acc;
  logic              w_fault;
  logic              w_ram_en;
  logic [XLEN-1:0]   w_lane_mask;
  logic [XLEN-1:0]   w_stat_rdata;
  logic [XLEN-1:0]   w_ram_q;

  logic              r_err;
  logic [XLEN-1:0]   r_fault_cnt;
  logic [XLEN-1:0]   r_fault_addr;
  logic              r_rd_sel_ram;
  logic [XLEN-1:0]   r_rd_mask;
  logic [XLEN-1:0]   r_rd_data;

  assign w_stat_off = mem_addr - STAT_BASE;
  assign w_acc      = mem_req && !rst;

  // Region decode: RAM is an aligned block, status is exactly three word addresses
  always_comb begin
    w_region = REG_NONE;
    if ((mem_addr & RAM_MASK) == RAM_BASE) begin
      w_region = REG_RAM;
    end else if (w_stat_off == XLEN'(STAT_CNT_OFF) ||
                 w_stat_off == XLEN'(STAT_ADDR_OFF) ||
                 w_stat_off == XLEN'(STAT_CLR_OFF)) begin
      w_region = REG_STAT;
    end
  end

  // All fault checks in parallel; writes to the read-only status words are faults too
  always_comb begin
    w_fault = 1'b0;
    if (!byteen_legal(mem_byteen))  w_fault = 1'b1;
    if (mem_addr[1:0] != 2'b00)     w_fault = 1'b1;
    if (w_region == REG_NONE)       w_fault = 1'b1;
    if (w_region == REG_STAT && mem_we && w_stat_off != XLEN'(STAT_CLR_OFF)) w_fault = 1'b1;
  end

  // Expand byte enables to a bit mask used to zero disabled lanes on reads
  always_comb begin
    w_lane_mask = '0;
    for (int b = 0; b < NB; b++) begin
      w_lane_mask[8*b +: 8] = {8{mem_byteen[b]}};
    end
  end

  // Status read mux; the clear register always reads as zero
  always_comb begin
    w_stat_rdata = '0;
    if (w_stat_off == XLEN'(STAT_CNT_OFF)) begin
      w_stat_rdata = r_fault_cnt;
    end else if (w_stat_off == XLEN'(STAT_ADDR_OFF)) begin
      w_stat_rdata = r_fault_addr;
    end
  end

  assign w_ram_en = w_acc && !w_fault && (w_region == REG_RAM);

  ram_bytelane #(
    .WORDS (RAM_WORDS),
    .WIDTH (XLEN)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (mem_we),
    .i_be    (mem_byteen),
    .i_addr  (mem_addr[AW+1:2]),
    .i_wdata (mem_wdata),
    .o_rdata (w_ram_q)
  );

  // Fault bookkeeping, clear handling and response registers, all updated on the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err        <= 1'b0;
      r_fault_cnt  <= '0;
      r_fault_addr <= '0;
      r_rd_sel_ram <= 1'b0;
      r_rd_mask    <= '0;
      r_rd_data    <= '0;
    end else begin
      r_err <= w_acc && w_fault;
      if (w_acc) begin
        if (w_fault) begin
          if (r_fault_cnt != '1) begin
            r_fault_cnt <= r_fault_cnt + XLEN'(1);
          end
          r_fault_addr <= mem_addr;
          if (!mem_we) begin
            r_rd_sel_ram <= 1'b0;
            r_rd_data    <= '0;
          end
        end else if (mem_we) begin
          // The only legal status write is the clear register
          if (w_region == REG_STAT) begin
            r_fault_cnt  <= '0;
            r_fault_addr <= '0;
          end
        end else if (w_region == REG_RAM) begin
          r_rd_sel_ram <= 1'b1;
          r_rd_mask    <= w_lane_mask;
        end else begin
          r_rd_sel_ram <= 1'b0;
          r_rd_data    <= w_stat_rdata;
        end
      end
    end
  end

  assign mem_rdata = r_rd_sel_ram ? (w_ram_q & r_rd_mask) : r_rd_data;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM lanes, fault detection, status window, reset.
// Each request is driven on the falling edge and its response sampled 1 time unit after the next rising edge.
module tb_data_mem_responder;

  localparam logic [31:0] RB = 32'h1000_0000;
  localparam logic [31:0] SB = 32'h1FFF_FF00;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic        mem_we;
  logic        mem_req;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  data_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_we     (mem_we),
    .mem_req    (mem_req),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    @(negedge clk);
    mem_req    = 1'b1;
    mem_addr   = a;
    mem_byteen = be;
    mem_we     = we;
    mem_wdata  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    mem_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input string tag, input logic err, input logic [31:0] rd);
    chk({tag, ".err"}, {31'd0, mem_err}, {31'd0, err});
    chk({tag, ".rdata"}, mem_rdata, rd);
  endtask

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_byteen = '0; mem_we = 1'b0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rsp("reset", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt0", 1'b0, 32'h0);
    req(RB + 32'h10, 4'b1111, 1'b1, 32'hDEADBEEF);  rsp("wr_full", 1'b0, 32'h0);
    req(RB + 32'h10, 4'b1111, 1'b0, '0);            rsp("raw_full", 1'b0, 32'hDEADBEEF);
    req(RB + 32'h20, 4'b1111, 1'b1, 32'h11223344);  rsp("preload", 1'b0, 32'hDEADBEEF);
    req(RB + 32'h20, 4'b0010, 1'b1, 32'h0000AA00);  rsp("wr_lane1", 1'b0, 32'hDEADBEEF);
    req(RB + 32'h20, 4'b1111, 1'b0, '0);            rsp("rd_merge", 1'b0, 32'h1122AA44);
    req(RB + 32'h20, 4'b1100, 1'b0, '0);            rsp("rd_hi", 1'b0, 32'h11220000);
    req(RB + 32'h20, 4'b0011, 1'b0, '0);            rsp("rd_lo", 1'b0, 32'h0000AA44);

    req(RB, 4'b0101, 1'b0, '0);                     rsp("be0101", 1'b1, 32'h0);
    idle();                                          rsp("idle_after_fault", 1'b0, 32'h0);
    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt1", 1'b0, 32'h1);
    req(SB + 32'h4, 4'b1111, 1'b0, '0);             rsp("addr1", 1'b0, RB);

    req(32'h0, 4'b1111, 1'b0, '0);                  rsp("unmapped", 1'b1, 32'h0);
    req(SB + 32'h4, 4'b1111, 1'b0, '0);             rsp("addr_unmapped", 1'b0, 32'h0);
    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt2", 1'b0, 32'h2);
    req(RB + 32'h6, 4'b1111, 1'b0, '0);             rsp("misaligned", 1'b1, 32'h0);
    req(SB + 32'h4, 4'b1111, 1'b0, '0);             rsp("addr_misal", 1'b0, RB + 32'h6);
    req(SB + 32'h8, 4'b1111, 1'b1, 32'h123);        rsp("clear_wr", 1'b0, RB + 32'h6);
    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt_cleared", 1'b0, 32'h0);
    req(SB + 32'h4, 4'b1111, 1'b0, '0);             rsp("addr_cleared", 1'b0, 32'h0);
    req(RB + 32'h10, 4'b1111, 1'b0, '0);            rsp("rd_ram10", 1'b0, 32'hDEADBEEF);
    req(SB + 32'h8, 4'b1111, 1'b0, '0);             rsp("rd_clr_reg", 1'b0, 32'h0);

    req(RB + 32'h10, 4'b1111, 1'b0, '0);            rsp("rd_ram10b", 1'b0, 32'hDEADBEEF);
    req(SB + 32'h0, 4'b1111, 1'b1, 32'hFFFF);       rsp("wr_cnt_ro", 1'b1, 32'hDEADBEEF);
    req(SB + 32'h4, 4'b1111, 1'b1, 32'hFFFF);       rsp("wr_addr_ro", 1'b1, 32'hDEADBEEF);
    req(RB + 32'h10, 4'b0000, 1'b1, 32'hFFFFFFFF);  rsp("wr_be0000", 1'b1, 32'hDEADBEEF);
    req(RB + 32'h10, 4'b1111, 1'b0, '0);            rsp("ram_untouched", 1'b0, 32'hDEADBEEF);
    req(RB + 32'h1000, 4'b1111, 1'b0, '0);          rsp("past_ram_end", 1'b1, 32'h0);
    req(RB + 32'hFFC, 4'b1111, 1'b1, 32'hCAFEF00D); rsp("wr_last_word", 1'b0, 32'h0);
    req(RB + 32'hFFC, 4'b1111, 1'b0, '0);           rsp("rd_last_word", 1'b0, 32'hCAFEF00D);
    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt4", 1'b0, 32'h4);
    req(SB + 32'hC, 4'b1111, 1'b0, '0);             rsp("past_stat_end", 1'b1, 32'h0);
    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt5", 1'b0, 32'h5);

    @(negedge clk);
    mem_req = 1'b0;
    force dut.r_fault_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_fault_cnt;
    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt_max", 1'b0, 32'hFFFF_FFFF);
    req(32'h0, 4'b1111, 1'b0, '0);                  rsp("fault_at_max", 1'b1, 32'h0);
    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt_saturated", 1'b0, 32'hFFFF_FFFF);
    req(SB + 32'h4, 4'b1111, 1'b0, '0);             rsp("addr_at_max", 1'b0, 32'h0);

    req(RB + 32'h10, 4'b1111, 1'b0, '0);            rsp("pre_reset_rd", 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b1; mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = RB + 32'h10; mem_byteen = 4'b1111; mem_wdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    rsp("reset_with_req", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    req(SB + 32'h0, 4'b1111, 1'b0, '0);             rsp("cnt_after_reset", 1'b0, 32'h0);
    req(RB + 32'h10, 4'b1111, 1'b0, '0);            rsp("ram_after_reset", 1'b0, 32'hDEADBEEF);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
